// File: rtl/comp_pkg.sv
// ---------------------------------------------------------------------------
// comp_pkg
//   Shared definitions for the compressor PWM driver.
//   - State encoding (ST_OFF / ST_RUN / ST_LOCKOUT) and the matching enum
//     used by the driver FSM.
//   - PWM_MAX   : highest level (100 % duty).
//   - PCNT_LAST : last value of the 15-step PWM phase counter.
//   - step_toward(): moves a level one LSB toward a target.
// ---------------------------------------------------------------------------
package comp_pkg;

    localparam logic [1:0] ST_OFF     = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    typedef enum logic [1:0] {
        S_OFF     = ST_OFF,
        S_RUN     = ST_RUN,
        S_LOCKOUT = ST_LOCKOUT
    } comp_state_e;

    localparam logic [3:0] PWM_MAX   = 4'd15;
    localparam logic [3:0] PCNT_LAST = 4'd14;

    // One slew step: +1 or -1 toward tgt, never past PWM_MAX or below 0.
    function automatic logic [3:0] step_toward(input logic [3:0] cur,
                                               input logic [3:0] tgt);
        logic [3:0] nxt;
        nxt = cur;
        if ((cur < tgt) && (cur != PWM_MAX)) begin
            nxt = cur + 4'd1;
        end else if (cur > tgt) begin
            nxt = cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/comp_pwm_tick.sv
// ---------------------------------------------------------------------------
// comp_pwm_tick
//   PWM timebase. A prescaler divides clk by TICK_DIV to produce a one-clock
//   tick; a phase counter (pcnt) advances on every tick through 0..14 and
//   wraps, so one PWM period is 15 ticks. period_end marks the tick on which
//   pcnt is at its last value, i.e. the final clock of a PWM period.
//
// Ports
//   clk         in   1  system clock
//   resetn      in   1  asynchronous, active-low reset
//   tick        out  1  one-clock pulse every TICK_DIV clocks
//   pcnt        out  4  PWM phase, 0..14
//   period_end  out  1  tick && pcnt == 14
// ---------------------------------------------------------------------------
module comp_pwm_tick
    import comp_pkg::*;
#(
    parameter int TICK_DIV = 3125
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       tick,
    output logic [3:0] pcnt,
    output logic       period_end
);

    // With TICK_DIV == 1 the prescaler collapses to a constant-zero flop and
    // tick is permanently high.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    logic [PW-1:0] presc;

    // Prescaler: counts 0..TICK_DIV-1 and restarts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_ONE;
        end
    end

    assign tick = (presc == PRESC_LAST);

    // PWM phase counter: advances once per tick and wraps 14 -> 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pcnt <= 4'd0;
        end else if (tick) begin
            if (pcnt == PCNT_LAST) begin
                pcnt <= 4'd0;
            end else begin
                pcnt <= pcnt + 4'd1;
            end
        end
    end

    assign period_end = tick && (pcnt == PCNT_LAST);

endmodule

// File: rtl/comp_pwm_driver.sv
// ---------------------------------------------------------------------------
// comp_pwm_driver
//   Turns the 4-bit compressor level requested by firmware into a glitch-free
//   PWM gate. Level changes are slew-limited (one LSB every RAMP_PERIODS PWM
//   periods), the compressor is held at level >= 1 for MIN_ON_PERIODS after a
//   start, and after a stop, a fault or a reset it is locked off for
//   MIN_OFF_PERIODS periods. An external fault forces the gate low at once.
//
// Ports
//   clk            in   1  system clock
//   resetn         in   1  asynchronous, active-low reset
//   level_in       in   4  requested level, 0 = off, 15 = full
//   fault          in   1  asynchronous fault, active high (synchronised here)
//   pwm_out        out  1  registered compressor gate
//   level_applied  out  4  level currently driving the PWM compare
//   state_o        out  2  0 = OFF, 1 = RUN, 2 = LOCKOUT
//   lockout        out  1  high while in LOCKOUT
// ---------------------------------------------------------------------------
module comp_pwm_driver
    import comp_pkg::*;
#(
    parameter int TICK_DIV        = 3125,
    parameter int RAMP_PERIODS    = 64,
    parameter int MIN_ON_PERIODS  = 1000,
    parameter int MIN_OFF_PERIODS = 1000,
    parameter int CNT_W           = 24
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] level_in,
    input  logic       fault,
    output logic       pwm_out,
    output logic [3:0] level_applied,
    output logic [1:0] state_o,
    output logic       lockout
);

    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_PERIODS - 1);
    localparam logic [CNT_W-1:0] MIN_ON    = CNT_W'(MIN_ON_PERIODS);
    localparam logic [CNT_W-1:0] MIN_OFF   = CNT_W'(MIN_OFF_PERIODS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             fault_meta;
    logic             fault_s;
    logic             unused_tick;
    logic [3:0]       pcnt;
    logic             period_end;

    comp_state_e      state;
    comp_state_e      state_nx;

    logic [3:0]       target;
    logic [3:0]       level_nx;
    logic [CNT_W-1:0] ramp_q;
    logic [CNT_W-1:0] ramp_nx;
    logic [CNT_W-1:0] on_q;
    logic [CNT_W-1:0] on_nx;
    logic [CNT_W-1:0] off_q;
    logic [CNT_W-1:0] off_nx;
    logic             pwm_nx;

    // PWM timebase; the raw tick is not needed at this level.
    comp_pwm_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk        (clk),
        .resetn     (resetn),
        .tick       (unused_tick),
        .pcnt       (pcnt),
        .period_end (period_end)
    );

    // Two-flop synchroniser for the asynchronous fault line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fault_meta <= 1'b0;
            fault_s    <= 1'b0;
        end else begin
            fault_meta <= fault;
            fault_s    <= fault_meta;
        end
    end

    // Datapath next-state: applied level and the ramp / min-on / min-off
    // counters. level_in only matters on period_end; a synchronised fault
    // overrides everything and keeps reloading the off counter while high.
    // While the min-on counter is still running the target is floored at 1,
    // so an early stop request cannot take the compressor below level 1.
    always_comb begin
        target   = level_in;
        level_nx = level_applied;
        ramp_nx  = ramp_q;
        on_nx    = on_q;
        off_nx   = off_q;

        if ((on_q != '0) && (level_in == 4'd0)) begin
            target = 4'd1;
        end

        if (fault_s) begin
            level_nx = 4'd0;
            ramp_nx  = '0;
            on_nx    = '0;
            off_nx   = MIN_OFF;
        end else if (period_end) begin
            case (state)
                S_OFF: begin
                    if (level_in != 4'd0) begin
                        level_nx = 4'd1;
                        ramp_nx  = '0;
                        on_nx    = MIN_ON;
                    end
                end
                S_RUN: begin
                    if (on_q != '0) begin
                        on_nx = on_q - CNT_ONE;
                    end
                    if (level_applied == target) begin
                        ramp_nx = '0;
                    end else if (ramp_q == RAMP_LAST) begin
                        level_nx = step_toward(level_applied, target);
                        ramp_nx  = '0;
                    end else begin
                        ramp_nx = ramp_q + CNT_ONE;
                    end
                    if (level_nx == 4'd0) begin
                        off_nx = MIN_OFF;
                    end
                end
                S_LOCKOUT: begin
                    level_nx = 4'd0;
                    ramp_nx  = '0;
                    on_nx    = '0;
                    if (off_q != '0) begin
                        off_nx = off_q - CNT_ONE;
                    end
                end
                default: begin
                    level_nx = 4'd0;
                    ramp_nx  = '0;
                    on_nx    = '0;
                    off_nx   = MIN_OFF;
                end
            endcase
        end
    end

    // Datapath registers. Reset arms the lockout with a full off count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_applied <= 4'd0;
            ramp_q        <= '0;
            on_q          <= '0;
            off_q         <= MIN_OFF;
        end else begin
            level_applied <= level_nx;
            ramp_q        <= ramp_nx;
            on_q          <= on_nx;
            off_q         <= off_nx;
        end
    end

    // FSM state register; reset lands in LOCKOUT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_LOCKOUT;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state. Only period_end moves the FSM, except a fault, which
    // forces LOCKOUT on the next clock. LOCKOUT leaves when the off counter
    // steps from 1 to 0.
    always_comb begin
        state_nx = state;
        if (fault_s) begin
            state_nx = S_LOCKOUT;
        end else if (period_end) begin
            case (state)
                S_OFF: begin
                    if (level_in != 4'd0) begin
                        state_nx = S_RUN;
                    end
                end
                S_RUN: begin
                    if (level_nx == 4'd0) begin
                        state_nx = S_LOCKOUT;
                    end
                end
                S_LOCKOUT: begin
                    if (off_q <= CNT_ONE) begin
                        state_nx = S_OFF;
                    end
                end
                default: begin
                    state_nx = S_LOCKOUT;
                end
            endcase
        end
    end

    // FSM outputs and the PWM compare. The gate only opens in RUN and is
    // suppressed combinationally by the synchronised fault, so the
    // registered output drops on the clock after fault_s rises.
    always_comb begin
        state_o = state;
        lockout = (state == S_LOCKOUT);
        pwm_nx  = (pcnt < level_applied) && (state == S_RUN) && !fault_s;
    end

    // Registered gate keeps pwm_out free of compare glitches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= pwm_nx;
        end
    end

endmodule

// File: tb/tb_comp_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_comp_pwm_driver
//   Scoreboard bench for comp_pwm_driver with TICK_DIV=2, RAMP_PERIODS=2,
//   MIN_ON=3, MIN_OFF=4 (one PWM period = 30 clk). Expected per-clock
//   observations are queued ahead of time, stamped with the clock index
//   since reset release, and popped by a monitor on the falling edge.
//   Period n spans rising edges 30n+1 .. 30n+30; the state and level of
//   period n are those set at edge 30n, and pwm_out after edge 30n+j is
//   (phase < level) in RUN with phase = (j-1)/TICK_DIV.
// ---------------------------------------------------------------------------
module tb_comp_pwm_driver;
    import comp_pkg::*;

    localparam int TICK_DIV = 2;
    localparam int PERIOD   = 30;

    localparam int F_PWM   = 0;
    localparam int F_LEVEL = 1;
    localparam int F_STATE = 2;
    localparam int F_LOCK  = 3;

    typedef struct {
        int          at;
        int          field;
        logic [31:0] want;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] level_in = 4'd15;
    logic       fault = 1'b0;
    logic       pwm_out;
    logic [3:0] level_applied;
    logic [1:0] state_o;
    logic       lockout;

    int          cyc;
    int          n_compared = 0;
    int          n_mismatch = 0;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_obs;
    string       mon_name;

    comp_pwm_driver #(
        .TICK_DIV        (2),
        .RAMP_PERIODS    (2),
        .MIN_ON_PERIODS  (3),
        .MIN_OFF_PERIODS (4),
        .CNT_W           (24)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .level_in      (level_in),
        .fault         (fault),
        .pwm_out       (pwm_out),
        .level_applied (level_applied),
        .state_o       (state_o),
        .lockout       (lockout)
    );

    always #5 clk = ~clk;

    // Clock index since reset release: after rising edge k, cyc == k.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc <= 0;
        end else begin
            cyc <= cyc + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] want);
        n_compared++;
        if (obs !== want) begin
            n_mismatch++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, want);
        end
    endtask

    task automatic push(input int at, input int field, input int want);
        sb_q.push_back('{at: at, field: field, want: 32'(want)});
    endtask

    // Queue a whole period band with constant state and level.
    task automatic expectPeriods(input int first, input int last,
                                 input logic [1:0] st, input int lvl);
        for (int n = first; n <= last; n++) begin
            for (int j = 1; j <= PERIOD; j++) begin
                push(n * PERIOD + j, F_PWM,
                     ((st == ST_RUN) && (((j - 1) / TICK_DIV) < lvl)) ? 1 : 0);
                if ((j == 1) || (j == 29)) begin
                    push(n * PERIOD + j, F_LEVEL, lvl);
                    push(n * PERIOD + j, F_STATE, int'(st));
                    push(n * PERIOD + j, F_LOCK, (st == ST_LOCKOUT) ? 1 : 0);
                end
            end
        end
    endtask

    // Period with a fault raised after edge j=2: RUN at lvl through j=4,
    // forced LOCKOUT with level 0 from j=5.
    task automatic expectFaultPeriod(input int n, input int lvl);
        for (int j = 1; j <= PERIOD; j++) begin
            push(n * PERIOD + j, F_PWM,
                 ((j <= 4) && (((j - 1) / TICK_DIV) < lvl)) ? 1 : 0);
            if ((j == 1) || (j == 4)) begin
                push(n * PERIOD + j, F_LEVEL, lvl);
                push(n * PERIOD + j, F_STATE, int'(ST_RUN));
            end
            if ((j == 5) || (j == 29)) begin
                push(n * PERIOD + j, F_LEVEL, 0);
                push(n * PERIOD + j, F_STATE, int'(ST_LOCKOUT));
                push(n * PERIOD + j, F_LOCK, 1);
            end
        end
    endtask

    task automatic waitCycle(input int target);
        int guard;
        guard = 0;
        while ((cyc != target) && (guard < 20000)) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) begin
            checkOutput("wait_timeout", 32'(cyc), 32'(target));
        end
    endtask

    task automatic applyStimulus(input int n, input int j,
                                 input logic [3:0] lvl, input logic flt);
        waitCycle(n * PERIOD + j);
        level_in = lvl;
        fault    = flt;
    endtask

    task automatic planPhaseA();
        expectPeriods(0, 3, ST_LOCKOUT, 0);
        expectPeriods(4, 4, ST_OFF, 0);
        for (int k = 1; k <= 14; k++) begin
            expectPeriods(5 + 2 * (k - 1), 6 + 2 * (k - 1), ST_RUN, k);
        end
        expectPeriods(33, 35, ST_RUN, 15);
        for (int m = 1; m <= 7; m++) begin
            expectPeriods(34 + 2 * m, 35 + 2 * m, ST_RUN, 15 - m);
        end
        expectPeriods(50, 51, ST_RUN, 8);
        for (int m = 1; m <= 5; m++) begin
            expectPeriods(50 + 2 * m, 51 + 2 * m, ST_RUN, 8 - m);
        end
        expectPeriods(62, 62, ST_RUN, 3);
        expectPeriods(63, 64, ST_RUN, 2);
        expectPeriods(65, 66, ST_RUN, 1);
        expectPeriods(67, 70, ST_LOCKOUT, 0);
        expectPeriods(71, 71, ST_OFF, 0);
        expectPeriods(72, 76, ST_RUN, 1);
        expectPeriods(77, 80, ST_LOCKOUT, 0);
        expectPeriods(81, 81, ST_OFF, 0);
        expectPeriods(82, 83, ST_RUN, 1);
        expectPeriods(84, 85, ST_RUN, 2);
        expectFaultPeriod(86, 3);
        expectPeriods(87, 89, ST_LOCKOUT, 0);
        expectPeriods(90, 90, ST_OFF, 0);
        expectFaultPeriod(91, 1);
        expectPeriods(92, 104, ST_LOCKOUT, 0);
        expectPeriods(105, 105, ST_OFF, 0);
        for (int k = 1; k <= 8; k++) begin
            expectPeriods(106 + 2 * (k - 1), 107 + 2 * (k - 1), ST_RUN, k);
        end
        for (int j = 1; j <= 10; j++) begin
            push(122 * PERIOD + j, F_PWM, 1);
            if ((j == 1) || (j == 10)) begin
                push(122 * PERIOD + j, F_LEVEL, 9);
                push(122 * PERIOD + j, F_STATE, int'(ST_RUN));
            end
        end
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_pwm"}, 32'(pwm_out), 32'd0);
        checkOutput({pfx, "_level"}, 32'(level_applied), 32'd0);
        checkOutput({pfx, "_state"}, 32'(state_o), 32'(ST_LOCKOUT));
        checkOutput({pfx, "_lockout"}, 32'(lockout), 32'd1);
    endtask

    // Monitor: pop every expectation stamped for this clock and compare.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            while ((sb_q.size() > 0) && (sb_q[0].at <= cyc)) begin
                mon_e = sb_q.pop_front();
                if (mon_e.at < cyc) begin
                    checkOutput($sformatf("missed@%0d", mon_e.at), 32'(cyc), 32'(mon_e.at));
                end else begin
                    case (mon_e.field)
                        F_PWM:   begin mon_obs = 32'(pwm_out);       mon_name = "pwm";     end
                        F_LEVEL: begin mon_obs = 32'(level_applied); mon_name = "level";   end
                        F_STATE: begin mon_obs = 32'(state_o);       mon_name = "state";   end
                        default: begin mon_obs = 32'(lockout);       mon_name = "lockout"; end
                    endcase
                    checkOutput($sformatf("%s@%0d", mon_name, mon_e.at), mon_obs, mon_e.want);
                end
            end
        end
    end

    initial begin
        $display("[TB] reset with level_in=15");
        repeat (3) @(posedge clk);
        #1;
        checkResetState("rst_a");
        planPhaseA();
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus(34, 10, 4'd8, 1'b0);
        applyStimulus(50, 15, 4'd3, 1'b0);
        applyStimulus(61, 10, 4'd0, 1'b0);
        applyStimulus(71, 10, 4'd15, 1'b0);
        applyStimulus(72, 10, 4'd0, 1'b0);
        applyStimulus(77, 10, 4'd5, 1'b0);
        $display("[TB] fault pulse in RUN");
        applyStimulus(86, 2, 4'd5, 1'b1);
        applyStimulus(86, 5, 4'd5, 1'b0);
        $display("[TB] fault held for ten periods");
        applyStimulus(91, 2, 4'd5, 1'b1);
        applyStimulus(101, 10, 4'd9, 1'b0);

        waitCycle(122 * PERIOD + 10);
        #1;
        checkOutput("sb_drain_a", 32'(sb_q.size()), 32'd0);
        $display("[TB] async reset mid-RUN at level 9");
        #1;
        resetn = 1'b0;
        #1;
        checkResetState("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hold_pwm", 32'(pwm_out), 32'd0);

        expectPeriods(0, 3, ST_LOCKOUT, 0);
        expectPeriods(4, 4, ST_OFF, 0);
        expectPeriods(5, 5, ST_RUN, 1);
        @(negedge clk);
        resetn = 1'b1;
        waitCycle(6 * PERIOD + 1);
        #1;
        checkOutput("sb_drain_b", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
